dcache_access_ctrl: RTL and testbench

//  Memory-stage sequencer behind the ALU/MEM pipeline register.

---
 rtl/dcache_access_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dcache_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_access_ctrl
// Purpose  : Memory-stage sequencer sitting behind the ALU/MEM pipeline
//            register. Converts load/store ops into req/ready transactions on
//            a multi-cycle data cache, freezes the upstream stages while a
//            transaction is outstanding, and produces a registered writeback
//            stream for the register-file stage.
// Ports    : clk, reset (async, active-low)
//            is_write_in/is_load_in/is_store_in, alu_result_in,
//            register_d_in, store_data_in   - op from ALU/MEM register
//            stall_out                      - combinational upstream freeze
//            dc_req/dc_we/dc_addr/dc_wdata  - cache request (registered)
//            dc_rdata/dc_ready              - cache response
//            wb_valid/wb_write/wb_reg/wb_data - writeback pulse
//            err_misalign/err_timeout       - single-cycle error pulses
//            stall_count                    - saturating stalled-cycle count
// Revision : 1.0 - initial release
// ============================================================================
module dcache_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_write_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  register_d_in,
  input  logic [31:0] store_data_in,
  output logic        stall_out,
  output logic        dc_req,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic [31:0] dc_rdata,
  input  logic        dc_ready,
  output logic        wb_valid,
  output logic        wb_write,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A zero timeout disables the abort path entirely.
  localparam bit            c_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] c_TO_LAST = c_TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [4:0]      r_rd;
  logic            r_write;

  logic w_mem_op;
  logic w_aligned;
  logic w_timeout_hit;

  assign w_mem_op      = is_load_in | is_store_in;
  assign w_aligned     = (alu_result_in[1:0] == 2'b00);
  // The counter holds the number of WAIT cycles already spent without an
  // answer, so matching TIMEOUT-1 aborts at the end of WAIT cycle TIMEOUT.
  assign w_timeout_hit = c_TO_EN && (r_to_cnt == c_TO_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and stall
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    stall_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && w_aligned) begin
          stall_out   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_out = 1'b1;
        // A response in the same cycle as the timeout wins.
        if (dc_ready || w_timeout_hit) begin
          w_state_nxt = S_DONE;
        end
      end
      // DONE lasts one cycle and releases the pipeline; the op still sitting
      // in the ALU/MEM register is the one just serviced and is ignored.
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Keep the freeze low while reset is held.
    if (!reset) begin
      stall_out = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Cache request, writeback and error registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dc_req       <= 1'b0;
      dc_we        <= 1'b0;
      dc_addr      <= '0;
      dc_wdata     <= '0;
      wb_valid     <= 1'b0;
      wb_write     <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      r_to_cnt     <= '0;
      r_rd         <= '0;
      r_write      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_write     <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            if (w_aligned) begin
              dc_req   <= 1'b1;
              // A simultaneous load+store flag is treated as a load.
              dc_we    <= is_store_in & ~is_load_in;
              dc_addr  <= alu_result_in;
              dc_wdata <= store_data_in;
              r_rd     <= register_d_in;
              r_write  <= is_write_in;
              r_to_cnt <= '0;
            end else begin
              err_misalign <= 1'b1;
            end
          end else begin
            wb_valid <= 1'b1;
            wb_write <= is_write_in & (register_d_in != 5'd0);
            wb_reg   <= register_d_in;
            wb_data  <= alu_result_in;
          end
        end
        S_WAIT: begin
          if (dc_ready) begin
            dc_req   <= 1'b0;
            wb_valid <= 1'b1;
            wb_reg   <= r_rd;
            if (!dc_we) begin
              wb_write <= r_write & (r_rd != 5'd0);
              wb_data  <= dc_rdata;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_timeout_hit) begin
              dc_req      <= 1'b0;
              err_timeout <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall_out && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_access_ctrl
// Purpose  : Self-checking bench for dcache_access_ctrl. A transaction-level
//            model of the memory stage predicts every output each cycle;
//            directed scenarios pin the model with literal expectations,
//            followed by randomized ops and cache latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_write_in, is_load_in, is_store_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [4:0]  register_d_in;
  logic        stall_out, dc_req, dc_we, dc_ready;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic        wb_valid, wb_write, err_misalign, err_timeout;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, stall_count;

  always #5 clk = ~clk;

  dcache_access_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .is_write_in(is_write_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
    .alu_result_in(alu_result_in), .register_d_in(register_d_in),
    .store_data_in(store_data_in), .stall_out(stall_out),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .wb_valid(wb_valid), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout), .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_settle, m_load, m_lw, m_last_stall;
  int          m_waited;
  logic [4:0]  m_rd;
  logic        m_req, m_we, m_wbv, m_wbw, m_wbd_ok, m_mis, m_to;
  logic [31:0] m_addr, m_wdata, m_wbdata, m_cnt;
  logic [4:0]  m_wbreg;

  task automatic model_reset();
    m_busy = 0; m_settle = 0; m_load = 0; m_lw = 0; m_last_stall = 0;
    m_waited = 0; m_rd = '0;
    m_req = 0; m_we = 0; m_wbv = 0; m_wbw = 0; m_wbd_ok = 0; m_mis = 0; m_to = 0;
    m_addr = '0; m_wdata = '0; m_wbdata = '0; m_cnt = '0; m_wbreg = '0;
  endtask

  function automatic bit m_stall();
    return m_busy || (!m_settle && (is_load_in || is_store_in) && (alu_result_in[1:0] == 2'b00));
  endfunction

  task automatic model_step();
    bit st;
    st = m_stall();
    m_last_stall = st;
    if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_wbv = 0; m_wbw = 0; m_wbd_ok = 0; m_mis = 0; m_to = 0;
    if (m_settle) begin
      m_settle = 0;
    end else if (m_busy) begin
      m_waited++;
      if (dc_ready) begin
        m_busy = 0; m_settle = 1; m_req = 0; m_wbv = 1;
        if (m_load) begin
          m_wbw = m_lw && (m_rd != 0); m_wbreg = m_rd; m_wbdata = dc_rdata; m_wbd_ok = 1;
        end
      end else if (TO != 0 && m_waited == TO) begin
        m_busy = 0; m_settle = 1; m_req = 0; m_to = 1;
      end
    end else if (is_load_in || is_store_in) begin
      if (alu_result_in[1:0] == 2'b00) begin
        m_busy = 1; m_waited = 0; m_req = 1;
        m_load = is_load_in; m_we = !is_load_in;
        m_addr = alu_result_in; m_wdata = store_data_in;
        m_rd = register_d_in; m_lw = is_write_in;
      end else begin
        m_mis = 1;
      end
    end else begin
      m_wbv = 1; m_wbw = is_write_in && (register_d_in != 0);
      m_wbreg = register_d_in; m_wbdata = alu_result_in; m_wbd_ok = 1;
    end
  endtask

  task automatic compare();
    chk("stall_out", {31'd0, stall_out}, {31'd0, m_stall()});
    chk("dc_req", {31'd0, dc_req}, {31'd0, m_req});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_wbv});
    chk("wb_write", {31'd0, wb_write}, {31'd0, m_wbw});
    chk("err_misalign", {31'd0, err_misalign}, {31'd0, m_mis});
    chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_to});
    chk("stall_count", stall_count, m_cnt);
    if (m_req) begin
      chk("dc_we", {31'd0, dc_we}, {31'd0, m_we});
      chk("dc_addr", dc_addr, m_addr);
      chk("dc_wdata", dc_wdata, m_wdata);
    end
    if (m_wbv && m_wbd_ok) begin
      chk("wb_reg", {27'd0, wb_reg}, {27'd0, m_wbreg});
      chk("wb_data", wb_data, m_wbdata);
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, then return 1 ns later so the caller can drive the next inputs.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_op(input bit ld, input bit st, input bit wr, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] sd);
    is_load_in = ld; is_store_in = st; is_write_in = wr;
    register_d_in = rd; alu_result_in = res; store_data_in = sd;
  endtask

  task automatic new_op();
    int k;
    logic [31:0] res;
    k = $urandom_range(0, 99);
    res = $urandom;
    if ($urandom_range(0, 4) != 0) res[1:0] = 2'b00;
    set_op((k < 30) || (k >= 50 && k < 58), (k >= 30 && k < 58), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), res, $urandom);
  endtask

  int  lat, wc;
  bit  prev_req;

  initial begin
    reset = 1'b0;
    dc_ready = 1'b0; dc_rdata = '0;
    set_op(0, 0, 0, 5'd0, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall_count", stall_count, 32'd0);
    chk("reset dc_req", {31'd0, dc_req}, 32'd0);
    chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    reset = 1'b1;

    // Asynchronous reset while a load is outstanding
    set_op(1, 0, 1, 5'd1, 32'h80, 32'd0);
    tick();
    chk("t1 req before reset", {31'd0, dc_req}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t1 req cleared", {31'd0, dc_req}, 32'd0);
    chk("t1 stall cleared", {31'd0, stall_out}, 32'd0);
    chk("t1 count cleared", stall_count, 32'd0);
    chk("t1 wb_valid cleared", {31'd0, wb_valid}, 32'd0);
    set_op(0, 0, 0, 5'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    // Load rd=5 at 0x100, answered on the third WAIT cycle
    set_op(1, 0, 1, 5'd5, 32'h100, 32'd0);
    dc_ready = 0;
    tick(); tick(); tick();
    dc_ready = 1; dc_rdata = 32'hDEADBEEF;
    tick();
    dc_ready = 0;
    chk("t2 wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t2 wb_reg", {27'd0, wb_reg}, 32'd5);
    chk("t2 wb_data", wb_data, 32'hDEADBEEF);
    chk("t2 stall_count", stall_count, 32'd4);
    chk("t2 done no stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("t2 no reissue", {31'd0, dc_req}, 32'd0);

    // Store answered on the first WAIT cycle
    set_op(0, 1, 0, 5'd7, 32'h40, 32'h12345678);
    tick();
    chk("t3 dc_we", {31'd0, dc_we}, 32'd1);
    chk("t3 dc_addr", dc_addr, 32'h40);
    chk("t3 dc_wdata", dc_wdata, 32'h12345678);
    dc_ready = 1;
    tick();
    dc_ready = 0;
    chk("t3 wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t3 wb_write", {31'd0, wb_write}, 32'd0);
    chk("t3 req dropped", {31'd0, dc_req}, 32'd0);
    tick();
    chk("t3 single request", {31'd0, dc_req}, 32'd0);

    // Two ALU ops back to back
    set_op(0, 0, 1, 5'd0, 32'd7, 32'd0);
    #1 chk("t4 no stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("t4 first wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t4 rd0 no write", {31'd0, wb_write}, 32'd0);
    set_op(0, 0, 1, 5'd3, 32'd9, 32'd0);
    tick();
    chk("t4 second wb_write", {31'd0, wb_write}, 32'd1);
    chk("t4 second wb_data", wb_data, 32'd9);
    chk("t4 second wb_reg", {27'd0, wb_reg}, 32'd3);

    // Misaligned load
    set_op(1, 0, 1, 5'd4, 32'h102, 32'd0);
    #1 chk("t5 no stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("t5 err_misalign", {31'd0, err_misalign}, 32'd1);
    chk("t5 no req", {31'd0, dc_req}, 32'd0);
    chk("t5 no wb", {31'd0, wb_valid}, 32'd0);

    // Timeout after TO WAIT cycles
    set_op(1, 0, 1, 5'd9, 32'h200, 32'd0);
    dc_ready = 0;
    repeat (1 + TO) tick();
    chk("t6 err_timeout", {31'd0, err_timeout}, 32'd1);
    chk("t6 req dropped", {31'd0, dc_req}, 32'd0);
    chk("t6 no wb", {31'd0, wb_valid}, 32'd0);
    chk("t6 done no stall", {31'd0, stall_out}, 32'd0);
    tick();
    // Ready on the last allowed WAIT cycle beats the timeout
    set_op(1, 0, 1, 5'd9, 32'h204, 32'd0);
    repeat (TO) tick();
    dc_ready = 1; dc_rdata = 32'hCAFEF00D;
    tick();
    dc_ready = 0;
    chk("t6b no timeout", {31'd0, err_timeout}, 32'd0);
    chk("t6b wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t6b wb_data", wb_data, 32'hCAFEF00D);
    tick();

    // Randomized traffic; the upstream only advances after a non-stalled edge
    prev_req = dc_req;
    lat = 1; wc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_last_stall) new_op();
      if (dc_req) begin
        if (!prev_req) begin
          lat = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(1, TO);
          wc = 0;
        end
        wc++;
        dc_ready = (wc == lat);
      end else begin
        dc_ready = ($urandom_range(0, 9) == 0);
      end
      prev_req = dc_req;
      dc_rdata = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
